// File: rtl/bus_xfer_ctrl_if.sv
// Signal bundle between the transfer controller, the arbiter, the masters and the memory port.
// The master modport is the controller's view; the slave modport is the surrounding system's view.
interface bus_xfer_ctrl_if #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 2
);
  logic [N_MASTERS-1:0]        bus_grant;
  logic                        bus_ack;
  logic [N_MASTERS-1:0]        m_we;
  logic [N_MASTERS*ADDR_W-1:0] m_addr;
  logic [N_MASTERS*LEN_W-1:0]  m_len;
  logic [N_MASTERS*DATA_W-1:0] m_wdata;
  logic [N_MASTERS-1:0]        m_wnext;
  logic [N_MASTERS-1:0]        m_rvalid;
  logic [DATA_W-1:0]           m_rdata;
  logic                        mem_req;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic                        mem_ready;
  logic [DATA_W-1:0]           mem_rdata;
  logic                        err_timeout;
  logic                        err_grant;

  modport master (
    input  bus_grant, m_we, m_addr, m_len, m_wdata, mem_ready, mem_rdata,
    output bus_ack, m_wnext, m_rvalid, m_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           err_timeout, err_grant
  );

  modport slave (
    output bus_grant, m_we, m_addr, m_len, m_wdata, mem_ready, mem_rdata,
    input  bus_ack, m_wnext, m_rvalid, m_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           err_timeout, err_grant
  );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Runs the granted master's burst on one memory port; mem_req one cycle after grant, read data one cycle after each beat.
// Stalls on mem_ready low, aborts after WAIT_MAX idle cycles, then pulses bus_ack for one cycle.
module bus_xfer_ctrl #(
  parameter int N_MASTERS = 3,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 2,
  parameter int WAIT_MAX  = 7
) (
  input logic             clk,
  input logic             reset_n,
  bus_xfer_ctrl_if.master bus
);
  localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, grant_idx;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q, beat_cnt;
  logic [WCNT_W-1:0]   wait_cnt;
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_tmo_q, err_gnt_q;
  logic                in_xfer, beat, last_beat, timeout, grant_lost, multi_grant;

  always_comb begin
    grant_idx = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--)
      if (bus.bus_grant[i]) grant_idx = IDX_W'(i);
  end

  assign in_xfer     = (state == XFER);
  assign beat        = in_xfer && bus.mem_ready;
  assign last_beat   = beat && (beat_cnt == len_q);
  assign timeout     = in_xfer && !bus.mem_ready && (wait_cnt == WAIT_LAST);
  assign grant_lost  = in_xfer && !bus.bus_grant[idx];
  assign multi_grant = (bus.bus_grant & (bus.bus_grant - N_MASTERS'(1))) != '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.bus_grant != '0) state_nxt = XFER;
      XFER: begin
        // A withdrawn grant abandons the burst without handing back an ack.
        if (grant_lost)                state_nxt = IDLE;
        else if (last_beat || timeout) state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req     = in_xfer;
    bus.mem_we      = in_xfer && we_q;
    bus.mem_addr    = addr_q;
    bus.mem_wdata   = bus.m_wdata[idx*DATA_W +: DATA_W];
    bus.bus_ack     = (state == ACK);
    bus.m_wnext     = (beat && we_q) ? (N_MASTERS'(1) << idx) : '0;
    bus.m_rvalid    = rvalid_q ? (N_MASTERS'(1) << idx) : '0;
    bus.m_rdata     = rdata_q;
    bus.err_timeout = err_tmo_q;
    bus.err_grant   = err_gnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_tmo_q <= 1'b0;
      err_gnt_q <= 1'b0;
    end else begin
      rvalid_q  <= 1'b0;
      err_tmo_q <= 1'b0;
      err_gnt_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.bus_grant != '0) begin
            idx       <= grant_idx;
            we_q      <= bus.m_we[grant_idx];
            addr_q    <= bus.m_addr[grant_idx*ADDR_W +: ADDR_W];
            len_q     <= bus.m_len[grant_idx*LEN_W +: LEN_W];
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            err_gnt_q <= multi_grant;
          end
        end
        XFER: begin
          if (grant_lost) begin
            err_gnt_q <= 1'b1;
          end else if (beat) begin
            addr_q   <= addr_q + ADDR_W'(1);
            beat_cnt <= beat_cnt + LEN_W'(1);
            wait_cnt <= '0;
            if (!we_q) begin
              rvalid_q <= 1'b1;
              rdata_q  <= bus.mem_rdata;
            end
          end else if (timeout) begin
            err_tmo_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl: stimulus queues expected beats/events with their cycle numbers,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_bus_xfer_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bus_xfer_ctrl_if #(.N_MASTERS(3), .ADDR_W(8), .DATA_W(8), .LEN_W(2)) bif ();

  bus_xfer_ctrl #(.N_MASTERS(3), .ADDR_W(8), .DATA_W(8), .LEN_W(2), .WAIT_MAX(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  typedef struct {
    int         cyc;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [2:0] wnext;
  } mem_exp_t;

  typedef struct {
    int         cyc;
    logic [2:0] vld;
    logic [7:0] dat;
  } rd_exp_t;

  mem_exp_t mem_q[$];
  rd_exp_t  rd_q[$];
  int       ack_q[$];
  int       tmo_q[$];
  int       gerr_q[$];
  mem_exp_t me;
  rd_exp_t  re;
  int       ev;
  int       cyc = 0;
  int       n_pass = 0;
  int       n_tot = 0;
  int       wptr;
  int       n;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data is a fixed scramble of the address.
  always_comb bif.mem_rdata = bif.mem_addr ^ 8'hA5;

  function automatic void chk(string nm, int act, int expv);
    n_tot++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
  endfunction

  function automatic void unexp(string nm);
    n_tot++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endfunction

  function automatic int out_vec();
    return int'({bif.bus_ack, bif.mem_req, bif.mem_we, bif.m_rvalid, bif.err_timeout,
                 bif.err_grant, bif.mem_addr, bif.m_rdata, bif.m_wnext});
  endfunction

  // Master 0 write source: advances to the next beat after each m_wnext[0].
  initial begin
    wptr = 0;
    bif.m_wdata = {8'h33, 8'h22, 8'hC0};
    forever begin
      @(negedge clk);
      if (bif.m_wnext[0]) begin
        @(posedge clk);
        #1;
        wptr++;
        bif.m_wdata[7:0] = 8'hC0 + 8'(wptr);
      end
    end
  end

  always @(negedge clk) begin
    if (bif.mem_req && bif.mem_ready) begin
      if (mem_q.size() == 0) unexp("mem_beat");
      else begin
        me = mem_q.pop_front();
        chk("beat_cycle", cyc, me.cyc);
        chk("mem_addr", int'(bif.mem_addr), int'(me.addr));
        chk("mem_we", int'(bif.mem_we), int'(me.we));
        chk("m_wnext", int'(bif.m_wnext), int'(me.wnext));
        if (me.we) chk("mem_wdata", int'(bif.mem_wdata), int'(me.wdata));
      end
    end else if (bif.m_wnext != 3'b000) unexp("m_wnext");
    if (bif.m_rvalid != 3'b000) begin
      if (rd_q.size() == 0) unexp("m_rvalid");
      else begin
        re = rd_q.pop_front();
        chk("rd_cycle", cyc, re.cyc);
        chk("m_rvalid", int'(bif.m_rvalid), int'(re.vld));
        chk("m_rdata", int'(bif.m_rdata), int'(re.dat));
      end
    end
    if (bif.bus_ack) begin
      if (ack_q.size() == 0) unexp("bus_ack");
      else begin ev = ack_q.pop_front(); chk("ack_cycle", cyc, ev); end
    end
    if (bif.err_timeout) begin
      if (tmo_q.size() == 0) unexp("err_timeout");
      else begin ev = tmo_q.pop_front(); chk("timeout_cycle", cyc, ev); end
    end
    if (bif.err_grant) begin
      if (gerr_q.size() == 0) unexp("err_grant");
      else begin ev = gerr_q.pop_front(); chk("err_grant_cycle", cyc, ev); end
    end
  end

  task automatic step(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [2:0] g, logic [2:0] we, logic [23:0] addr, logic [5:0] len, logic rdy);
    bif.bus_grant = g;
    bif.m_we      = we;
    bif.m_addr    = addr;
    bif.m_len     = len;
    bif.mem_ready = rdy;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(3'b000, 3'b000, 24'h0, 6'h0, 1'b1);

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      step(1);
      drive(3'($urandom), 3'($urandom), 24'($urandom), 6'($urandom), 1'($urandom));
      @(negedge clk);
      chk("reset_outputs", out_vec(), 0);
    end
    step(1);
    reset_n = 1'b1;
    drive(3'b000, 3'b000, 24'h0, 6'h0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("idle_mem_req", int'(bif.mem_req), 0);
    end
    step(1);

    // Read burst, master 1, 0x10, 4 beats, no waits
    n = cyc;
    drive(3'b010, 3'b000, {8'h00, 8'h10, 8'h00}, {2'd0, 2'd3, 2'd0}, 1'b1);
    mem_q.push_back('{n + 1, 1'b0, 8'h10, 8'h00, 3'b000});
    mem_q.push_back('{n + 2, 1'b0, 8'h11, 8'h00, 3'b000});
    mem_q.push_back('{n + 3, 1'b0, 8'h12, 8'h00, 3'b000});
    mem_q.push_back('{n + 4, 1'b0, 8'h13, 8'h00, 3'b000});
    rd_q.push_back('{n + 2, 3'b010, 8'hB5});
    rd_q.push_back('{n + 3, 3'b010, 8'hB4});
    rd_q.push_back('{n + 4, 3'b010, 8'hB7});
    rd_q.push_back('{n + 5, 3'b010, 8'hB6});
    ack_q.push_back(n + 5);
    step(6);
    drive(3'b000, 3'b000, 24'h0, 6'h0, 1'b1);
    step(2);

    // Write burst, master 0, 0xFE wrapping, 3 beats, ready every other cycle
    n = cyc;
    drive(3'b001, 3'b001, {8'h00, 8'h00, 8'hFE}, {2'd0, 2'd0, 2'd2}, 1'b0);
    mem_q.push_back('{n + 2, 1'b1, 8'hFE, 8'hC0, 3'b001});
    mem_q.push_back('{n + 4, 1'b1, 8'hFF, 8'hC1, 3'b001});
    mem_q.push_back('{n + 6, 1'b1, 8'h00, 8'hC2, 3'b001});
    ack_q.push_back(n + 7);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      bif.mem_ready = (k % 2 == 0);
    end
    step(2);
    drive(3'b000, 3'b000, 24'h0, 6'h0, 1'b1);
    step(2);

    // Timeout, master 2, memory never ready
    n = cyc;
    drive(3'b100, 3'b000, {8'h40, 8'h00, 8'h00}, {2'd1, 2'd0, 2'd0}, 1'b0);
    tmo_q.push_back(n + 8);
    ack_q.push_back(n + 8);
    step(7);
    @(negedge clk);
    chk("tmo_mem_req_held", int'(bif.mem_req), 1);
    step(1);
    @(negedge clk);
    chk("tmo_mem_req_dropped", int'(bif.mem_req), 0);
    step(1);
    drive(3'b000, 3'b000, 24'h0, 6'h0, 1'b1);
    step(2);

    // Grant withdrawn mid-burst: err_grant, no bus_ack
    n = cyc;
    drive(3'b010, 3'b000, {8'h00, 8'h20, 8'h00}, {2'd0, 2'd3, 2'd0}, 1'b0);
    gerr_q.push_back(n + 3);
    step(2);
    bif.bus_grant = 3'b000;
    step(1);
    @(negedge clk);
    chk("grant_lost_mem_req", int'(bif.mem_req), 0);
    step(3);
    bif.mem_ready = 1'b1;

    // Two grant bits: err_grant, lowest master served
    n = cyc;
    drive(3'b011, 3'b000, {8'h00, 8'h50, 8'h30}, {2'd0, 2'd3, 2'd0}, 1'b1);
    gerr_q.push_back(n + 1);
    mem_q.push_back('{n + 1, 1'b0, 8'h30, 8'h00, 3'b000});
    rd_q.push_back('{n + 2, 3'b001, 8'h95});
    ack_q.push_back(n + 2);
    step(3);
    drive(3'b000, 3'b000, 24'h0, 6'h0, 1'b1);
    step(2);

    // Reset mid-burst, then a fresh burst from the new address
    n = cyc;
    drive(3'b100, 3'b000, {8'h60, 8'h00, 8'h00}, {2'd3, 2'd0, 2'd0}, 1'b1);
    mem_q.push_back('{n + 1, 1'b0, 8'h60, 8'h00, 3'b000});
    step(2);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", out_vec(), 0);
    step(1);
    reset_n = 1'b1;
    bif.m_addr = {8'h70, 8'h00, 8'h00};
    bif.m_len  = {2'd1, 2'd0, 2'd0};
    mem_q.push_back('{n + 4, 1'b0, 8'h70, 8'h00, 3'b000});
    mem_q.push_back('{n + 5, 1'b0, 8'h71, 8'h00, 3'b000});
    rd_q.push_back('{n + 5, 3'b100, 8'hD5});
    rd_q.push_back('{n + 6, 3'b100, 8'hD4});
    ack_q.push_back(n + 6);
    step(4);
    drive(3'b000, 3'b000, 24'h0, 6'h0, 1'b1);
    step(3);

    chk("mem_q_left", mem_q.size(), 0);
    chk("rd_q_left", rd_q.size(), 0);
    chk("ack_q_left", ack_q.size(), 0);
    chk("tmo_q_left", tmo_q.size(), 0);
    chk("gerr_q_left", gerr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
